// File: rtl/frame_fifo_pkg.sv
// Shared types for the frame-committing FIFO.
// Write-side state and pointer helper.
package frame_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECORD,
        DROP,
        PATCH
    } state_t;

    // Wrap a pointer sum into a 2**log2 ring.
    function automatic int unsigned ptr_wrap(
        input int unsigned p,
        input int unsigned log2
    );
        return p & ((32'd1 << log2) - 32'd1);
    endfunction

endpackage

// File: rtl/frame_fifo_v2_ram_2p.sv
// Two-port RAM: one synchronous write port.
// One asynchronous read port for first-word-fall-through.
module ram_2p #(
    parameter int WIDTH      = 9,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    // Storage carries no reset; readers only see committed entries.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/frame_fifo_v2.sv
// Frame-committing FIFO with length trailer and optional header patch.
// Frames become visible only once fully written; overflowing frames drop.
module frame_fifo_v2
    import frame_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 9,
    parameter int LEN_WIDTH  = 8,
    parameter int LEN_OFFSET = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_frame_valid,
    input  logic                  in_abort,
    input  logic                  populate_len,
    output logic                  in_ready,
    output logic                  overflow,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_eof,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2-1:0] frame_count,
    output logic [15:0]           drop_count
);

    localparam logic [DEPTH_LOG2-1:0] P_ONE = 1;
    localparam logic [LEN_WIDTH-1:0]  L_ONE = 1;

    state_t                  state, state_d;
    logic [DEPTH_LOG2-1:0]   head, head_d, head_nx;
    logic [DEPTH_LOG2-1:0]   tail;
    logic [DEPTH_LOG2-1:0]   commit_ptr, commit_d;
    logic [DEPTH_LOG2-1:0]   frame_start, fstart_d;
    logic [DEPTH_LOG2-1:0]   patch_addr;
    logic [LEN_WIDTH-1:0]    len, len_d, len_inc;
    logic                    full, pop, pop_eof;
    logic                    ovf_d, drop_inc, commit_inc;
    logic                    we;
    logic [DEPTH_LOG2-1:0]   waddr;
    logic [DATA_WIDTH:0]     wdata, rdata;

    assign head_nx    = head + P_ONE;
    assign full       = (head_nx == tail);
    assign len_inc    = (len == '1) ? len : len + L_ONE;
    assign patch_addr = DEPTH_LOG2'(ptr_wrap(32'(frame_start) + 32'(LEN_OFFSET),
                                             DEPTH_LOG2));

    assign in_ready  = ((state == IDLE) || (state == RECORD)) && !full;
    assign out_valid = (tail != commit_ptr);
    assign out_data  = rdata[DATA_WIDTH-1:0];
    assign out_eof   = out_valid && rdata[DATA_WIDTH];
    assign pop       = out_valid && out_ready;
    assign pop_eof   = pop && rdata[DATA_WIDTH];

    ram_2p #(
        .WIDTH      (DATA_WIDTH + 1),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (tail),
        .rdata (rdata)
    );

    // Write-side FSM: record, drop, trailer and header patch.
    always_comb begin
        state_d    = state;
        head_d     = head;
        commit_d   = commit_ptr;
        fstart_d   = frame_start;
        len_d      = len;
        we         = 1'b0;
        waddr      = head;
        wdata      = '0;
        ovf_d      = 1'b0;
        drop_inc   = 1'b0;
        commit_inc = 1'b0;
        unique case (state)
            IDLE: begin
                fstart_d = head;
                len_d    = '0;
                if (in_frame_valid) begin
                    if (in_abort) begin
                        drop_inc = 1'b1;
                        state_d  = DROP;
                    end else begin
                        state_d = RECORD;
                        if (in_valid && !full) begin
                            we     = 1'b1;
                            wdata  = {1'b0, in_data};
                            head_d = head_nx;
                            len_d  = L_ONE;
                        end
                    end
                end
            end
            RECORD: begin
                if (in_abort) begin
                    head_d   = frame_start;
                    drop_inc = 1'b1;
                    state_d  = DROP;
                end else if (!in_frame_valid) begin
                    if (len == '0) begin
                        state_d = IDLE;
                    end else if (full) begin
                        head_d   = frame_start;
                        ovf_d    = 1'b1;
                        drop_inc = 1'b1;
                        state_d  = DROP;
                    end else begin
                        we     = 1'b1;
                        wdata  = {1'b1, DATA_WIDTH'(len)};
                        head_d = head_nx;
                        if (populate_len && (32'(len) > LEN_OFFSET)) begin
                            state_d = PATCH;
                        end else begin
                            commit_d   = head_nx;
                            commit_inc = 1'b1;
                            state_d    = IDLE;
                        end
                    end
                end else if (in_valid) begin
                    if (full) begin
                        head_d   = frame_start;
                        ovf_d    = 1'b1;
                        drop_inc = 1'b1;
                        state_d  = DROP;
                    end else begin
                        we     = 1'b1;
                        wdata  = {1'b0, in_data};
                        head_d = head_nx;
                        len_d  = len_inc;
                    end
                end
            end
            DROP: begin
                if (!in_frame_valid) begin
                    state_d = IDLE;
                end
            end
            PATCH: begin
                we         = 1'b1;
                waddr      = patch_addr;
                wdata      = {1'b0, DATA_WIDTH'(len)};
                commit_d   = head;
                commit_inc = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointers and overflow pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            head        <= '0;
            tail        <= '0;
            commit_ptr  <= '0;
            frame_start <= '0;
            len         <= '0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_d;
            head        <= head_d;
            commit_ptr  <= commit_d;
            frame_start <= fstart_d;
            len         <= len_d;
            overflow    <= ovf_d;
            if (pop) begin
                tail <= tail + P_ONE;
            end
        end
    end

    // Committed-frame and drop counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            if (commit_inc && !pop_eof) begin
                frame_count <= frame_count + P_ONE;
            end else if (!commit_inc && pop_eof) begin
                frame_count <= frame_count - P_ONE;
            end
            if (drop_inc && (drop_count != '1)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_frame_fifo_v2.sv
// Directed bench for frame_fifo_v2 (8-entry ring).
// Expected streams are built from hand-computed frame contents.
module tb_frame_fifo_v2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid, in_frame_valid, in_abort, populate_len;
    logic       in_ready, overflow;
    logic [7:0] out_data;
    logic       out_eof, out_valid, out_ready;
    logic [2:0] frame_count;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;

    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    int         ovf_cnt;
    logic       seen_valid;
    logic [2:0] fc_max;

    frame_fifo_v2 #(
        .DATA_WIDTH (8),
        .DEPTH_LOG2 (3),
        .LEN_WIDTH  (8),
        .LEN_OFFSET (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_frame_valid (in_frame_valid),
        .in_abort       (in_abort),
        .populate_len   (populate_len),
        .in_ready       (in_ready),
        .overflow       (overflow),
        .out_data       (out_data),
        .out_eof        (out_eof),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .frame_count    (frame_count),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) got_q.push_back({out_eof, out_data});
            if (overflow) ovf_cnt <= ovf_cnt + 1;
            if (out_valid) seen_valid <= 1'b1;
            if (frame_count > fc_max) fc_max <= frame_count;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] base, input int n,
                              input logic popl);
        populate_len = popl;
        for (int i = 0; i < n; i++) begin
            in_frame_valid = 1'b1;
            in_valid       = 1'b1;
            in_data        = base + 8'(i);
            tick();
        end
        in_frame_valid = 1'b0;
        in_valid       = 1'b0;
        tick();
        tick();
        populate_len = 1'b0;
    endtask

    task automatic exp_frame(input logic [7:0] base, input int n,
                             input logic popl);
        for (int i = 0; i < n; i++) begin
            if (popl && i == 2 && n > 2) exp_q.push_back({1'b0, 8'(n)});
            else exp_q.push_back({1'b0, base + 8'(i)});
        end
        exp_q.push_back({1'b1, 8'(n)});
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < 40 && out_valid; i++) tick();
        chk({tag, "_drain"}, 32'(out_valid), 32'd0);
        out_ready = 1'b0;
    endtask

    task automatic cmp_q(input string tag);
        chk({tag, "_n"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        in_data = '0;
        in_valid = 1'b0;
        in_frame_valid = 1'b0;
        in_abort = 1'b0;
        populate_len = 1'b0;
        out_ready = 1'b0;
        ovf_cnt = 0;
        seen_valid = 1'b0;
        fc_max = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_eof", 32'(out_eof), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_fc", 32'(frame_count), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);

        // 1: plain 5-word frame
        send_frame(8'hA0, 5, 1'b0);
        chk("t1_fc", 32'(frame_count), 32'd1);
        chk("t1_valid", 32'(out_valid), 32'd1);
        exp_frame(8'hA0, 5, 1'b0);
        drain("t1");
        cmp_q("t1");
        chk("t1_fc_end", 32'(frame_count), 32'd0);

        // 2: length patch, header wraps the ring
        send_frame(8'h10, 4, 1'b1);
        chk("t2_fc", 32'(frame_count), 32'd1);
        exp_frame(8'h10, 4, 1'b1);
        drain("t2");
        cmp_q("t2");

        // 3: 9-word frame into 7 free entries
        ovf_cnt = 0;
        seen_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_frame_valid = 1'b1;
            in_valid = 1'b1;
            in_data = 8'(8'h30 + i);
            tick();
            if (i == 6) chk("t3_full_rdy", 32'(in_ready), 32'd0);
        end
        in_frame_valid = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        chk("t3_ovf_cnt", 32'(ovf_cnt), 32'd1);
        chk("t3_drop", 32'(drop_count), 32'd1);
        chk("t3_seen_valid", 32'(seen_valid), 32'd0);
        chk("t3_in_ready", 32'(in_ready), 32'd1);
        chk("t3_fc", 32'(frame_count), 32'd0);

        // 4: back-to-back frames with a continuous reader
        fc_max = '0;
        out_ready = 1'b1;
        send_frame(8'h41, 3, 1'b0);
        send_frame(8'h51, 3, 1'b0);
        exp_frame(8'h41, 3, 1'b0);
        exp_frame(8'h51, 3, 1'b0);
        drain("t4");
        cmp_q("t4");
        chk("t4_fc_max_le2", 32'(fc_max <= 3'd2), 32'd1);
        chk("t4_fc", 32'(frame_count), 32'd0);

        // 5: abort on word 3 of 6, then a 2-word frame
        for (int i = 0; i < 6; i++) begin
            in_frame_valid = 1'b1;
            in_valid = 1'b1;
            in_abort = (i == 2);
            in_data = 8'(8'hE0 + i);
            tick();
        end
        in_abort = 1'b0;
        in_frame_valid = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("t5_drop", 32'(drop_count), 32'd2);
        chk("t5_valid", 32'(out_valid), 32'd0);
        send_frame(8'h61, 2, 1'b1);
        exp_frame(8'h61, 2, 1'b1);
        drain("t5");
        cmp_q("t5");

        // 6: async reset mid-frame with one committed frame
        send_frame(8'h71, 1, 1'b0);
        chk("t6_fc_pre", 32'(frame_count), 32'd1);
        chk("t6_valid_pre", 32'(out_valid), 32'd1);
        in_frame_valid = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h81;
        tick();
        in_data = 8'h82;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_fc", 32'(frame_count), 32'd0);
        chk("t6_rst_drop", 32'(drop_count), 32'd0);
        chk("t6_rst_rdy", 32'(in_ready), 32'd1);
        in_frame_valid = 1'b0;
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(8'h91, 3, 1'b1);
        chk("t6_fc_post", 32'(frame_count), 32'd1);
        exp_frame(8'h91, 3, 1'b1);
        drain("t6");
        cmp_q("t6");
        chk("t6_fc_end", 32'(frame_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
